// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-approach phase sequencer; timing counts 1 Hz tick pulses, one cycle from input to lamps.
// Skips unrequested left-turn phases, rests in green without opposing demand, flashes yellow when disabled.
module traffic_phase_scheduler #(
  parameter int CNT_W     = 6,
  parameter int T_LEFT    = 15,
  parameter int T_GREEN_A = 40,
  parameter int T_GREEN_B = 30,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             veh_req_a,
  input  logic             veh_req_b,
  input  logic             left_req_a,
  input  logic             left_req_b,
  output logic             left_turn_a,
  output logic             green_a,
  output logic             yellow_a,
  output logic             red_a,
  output logic             left_turn_b,
  output logic             green_b,
  output logic             yellow_b,
  output logic             red_b,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] countdown
);

  typedef enum logic [3:0] {
    ALLRED_A = 4'd0,
    A_LEFT   = 4'd1,
    A_GREEN  = 4'd2,
    A_YELLOW = 4'd3,
    ALLRED_B = 4'd4,
    B_LEFT   = 4'd5,
    B_GREEN  = 4'd6,
    B_YELLOW = 4'd7,
    FLASH    = 4'd8
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       LAMPS_ALLRED = 8'b0001_0001;

  phase_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_a, pend_b, pend_left_a, pend_left_b;
  logic             pend_a_nxt, pend_b_nxt, pend_left_a_nxt, pend_left_b_nxt;
  logic             flash_yel, flash_yel_nxt;
  // {left_a, green_a, yellow_a, red_a, left_b, green_b, yellow_b, red_b}
  logic [7:0]       lamps, lamps_nxt;

  function automatic logic [CNT_W-1:0] dur(input phase_t p);
    case (p)
      ALLRED_A, ALLRED_B: dur = CNT_W'(T_ALLRED);
      A_LEFT, B_LEFT:     dur = CNT_W'(T_LEFT);
      A_GREEN:            dur = CNT_W'(T_GREEN_A);
      B_GREEN:            dur = CNT_W'(T_GREEN_B);
      A_YELLOW, B_YELLOW: dur = CNT_W'(T_YELLOW);
      default:            dur = '0;
    endcase
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flash_yel_nxt = 1'b0;

    if (!enable) begin
      state_nxt = FLASH;
      cnt_nxt   = '0;
      if (state != FLASH) flash_yel_nxt = 1'b1;
      else                flash_yel_nxt = tick ? ~flash_yel : flash_yel;
    end else if (state == FLASH) begin
      state_nxt = ALLRED_A;
      cnt_nxt   = CNT_W'(T_ALLRED);
    end else if (tick) begin
      if (cnt > CNT_ONE) begin
        cnt_nxt = cnt - CNT_ONE;
      end else begin
        // Greens without opposing demand keep state; countdown stays at 1.
        case (state)
          ALLRED_A: state_nxt = pend_left_a ? A_LEFT : A_GREEN;
          A_LEFT:   state_nxt = A_GREEN;
          A_GREEN:  if (pend_b || pend_left_b) state_nxt = A_YELLOW;
          A_YELLOW: state_nxt = ALLRED_B;
          ALLRED_B: state_nxt = pend_left_b ? B_LEFT : B_GREEN;
          B_LEFT:   state_nxt = B_GREEN;
          B_GREEN:  if (pend_a || pend_left_a) state_nxt = B_YELLOW;
          B_YELLOW: state_nxt = ALLRED_A;
          default:  state_nxt = ALLRED_A;
        endcase
        if (state_nxt != state) cnt_nxt = dur(state_nxt);
      end
    end

    pend_a_nxt      = pend_a      | (veh_req_a  && state != A_GREEN);
    pend_b_nxt      = pend_b      | (veh_req_b  && state != B_GREEN);
    pend_left_a_nxt = pend_left_a | (left_req_a && state != A_LEFT);
    pend_left_b_nxt = pend_left_b | (left_req_b && state != B_LEFT);
    if (state_nxt != state) begin
      case (state_nxt)
        A_GREEN: pend_a_nxt      = 1'b0;
        B_GREEN: pend_b_nxt      = 1'b0;
        A_LEFT:  pend_left_a_nxt = 1'b0;
        B_LEFT:  pend_left_b_nxt = 1'b0;
        default: ;
      endcase
    end

    case (state_nxt)
      A_LEFT:   lamps_nxt = 8'b1000_0001;
      A_GREEN:  lamps_nxt = 8'b0100_0001;
      A_YELLOW: lamps_nxt = 8'b0010_0001;
      B_LEFT:   lamps_nxt = 8'b0001_1000;
      B_GREEN:  lamps_nxt = 8'b0001_0100;
      B_YELLOW: lamps_nxt = 8'b0001_0010;
      FLASH:    lamps_nxt = {2'b00, flash_yel_nxt, 3'b000, flash_yel_nxt, 1'b0};
      default:  lamps_nxt = LAMPS_ALLRED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALLRED_A;
      cnt         <= CNT_W'(T_ALLRED);
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      pend_left_a <= 1'b0;
      pend_left_b <= 1'b0;
      flash_yel   <= 1'b0;
      lamps       <= LAMPS_ALLRED;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend_a      <= pend_a_nxt;
      pend_b      <= pend_b_nxt;
      pend_left_a <= pend_left_a_nxt;
      pend_left_b <= pend_left_b_nxt;
      flash_yel   <= flash_yel_nxt;
      lamps       <= lamps_nxt;
    end
  end

  assign {left_turn_a, green_a, yellow_a, red_a, left_turn_b, green_b, yellow_b, red_b} = lamps;
  assign phase     = state;
  assign countdown = cnt;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected phase/countdown/lamps/dwell per output change;
// the monitor pops on every change of phase or lamps and compares.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, tick, enable;
  logic       veh_req_a, veh_req_b, left_req_a, left_req_b;
  logic       left_turn_a, green_a, yellow_a, red_a;
  logic       left_turn_b, green_b, yellow_b, red_b;
  logic [3:0] phase;
  logic [5:0] countdown;

  int checks = 0;
  int errors = 0;

  traffic_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable),
    .veh_req_a(veh_req_a), .veh_req_b(veh_req_b),
    .left_req_a(left_req_a), .left_req_b(left_req_b),
    .left_turn_a(left_turn_a), .green_a(green_a), .yellow_a(yellow_a), .red_a(red_a),
    .left_turn_b(left_turn_b), .green_b(green_b), .yellow_b(yellow_b), .red_b(red_b),
    .phase(phase), .countdown(countdown)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ph;
    logic [5:0] cd;
    logic [7:0] lamps;
    int         dwell;  // ticks spent since previous output change; -1 = not checked
  } exp_t;

  exp_t expq[$];

  function automatic logic [7:0] lamps_of(input logic [3:0] p, input logic y);
    case (p)
      4'd1:    lamps_of = 8'b1000_0001;
      4'd2:    lamps_of = 8'b0100_0001;
      4'd3:    lamps_of = 8'b0010_0001;
      4'd5:    lamps_of = 8'b0001_1000;
      4'd6:    lamps_of = 8'b0001_0100;
      4'd7:    lamps_of = 8'b0001_0010;
      4'd8:    lamps_of = y ? 8'b0010_0010 : 8'b0000_0000;
      default: lamps_of = 8'b0001_0001;
    endcase
  endfunction

  task automatic expect_ev(input logic [3:0] p, input logic [5:0] c, input int d, input logic y = 1'b0);
    exp_t e;
    e.ph = p; e.cd = c; e.lamps = lamps_of(p, y); e.dwell = d;
    expq.push_back(e);
  endtask

  // Monitor
  logic [3:0] prev_ph    = 4'bx;
  logic [7:0] prev_lamps = 8'bx;
  int         dwell      = 0;
  bit         last_tick  = 1'b0;
  int         ev_num     = 0;

  always @(negedge clk) begin
    logic [7:0] lamps_now;
    exp_t       e;
    lamps_now = {left_turn_a, green_a, yellow_a, red_a, left_turn_b, green_b, yellow_b, red_b};
    if (last_tick) dwell++;
    if (phase !== prev_ph || lamps_now !== prev_lamps) begin
      ev_num++;
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event #%0d: phase=%0d countdown=%0d lamps=%b, nothing expected",
                 ev_num, phase, countdown, lamps_now);
      end else begin
        e = expq.pop_front();
        checks++;
        if (phase !== e.ph) begin
          errors++;
          $display("FAIL phase ev#%0d: got %0d want %0d", ev_num, phase, e.ph);
        end
        checks++;
        if (countdown !== e.cd) begin
          errors++;
          $display("FAIL countdown ev#%0d (phase %0d): got %0d want %0d", ev_num, e.ph, countdown, e.cd);
        end
        checks++;
        if (lamps_now !== e.lamps) begin
          errors++;
          $display("FAIL lamps ev#%0d (phase %0d): got %b want %b", ev_num, e.ph, lamps_now, e.lamps);
        end
        if (e.dwell >= 0) begin
          checks++;
          if (dwell != e.dwell) begin
            errors++;
            $display("FAIL dwell ev#%0d (into phase %0d): got %0d ticks want %0d", ev_num, e.ph, dwell, e.dwell);
          end
        end
      end
      dwell      = 0;
      prev_ph    = phase;
      prev_lamps = lamps_now;
    end
    last_tick = tick && !reset;
  end

  // Stimulus: all drives happen 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n, input int gap = 1);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      if (gap > 0) begin
        tick = 1'b0;
        cyc(gap);
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b1;
    veh_req_a = 1'b0; veh_req_b = 1'b0; left_req_a = 1'b0; left_req_b = 1'b0;

    // Reset state
    expect_ev(4'd0, 6'd2, -1);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Full cycle with every request held, back-to-back ticks
    veh_req_a = 1'b1; veh_req_b = 1'b1; left_req_a = 1'b1; left_req_b = 1'b1;
    expect_ev(4'd1, 6'd15, 2);
    expect_ev(4'd2, 6'd40, 15);
    expect_ev(4'd3, 6'd5,  40);
    expect_ev(4'd4, 6'd2,  5);
    expect_ev(4'd5, 6'd15, 2);
    expect_ev(4'd6, 6'd30, 15);
    expect_ev(4'd7, 6'd5,  30);
    expect_ev(4'd0, 6'd2,  5);
    ticks(114, 0);
    veh_req_a = 1'b0; veh_req_b = 1'b0; left_req_a = 1'b0; left_req_b = 1'b0;

    // Reset mid A_GREEN, with a tick in the reset cycle that must be ignored
    expect_ev(4'd1, 6'd15, 2);
    expect_ev(4'd2, 6'd40, 15);
    ticks(27);
    ticks(10);
    expect_ev(4'd0, 6'd2, -1);
    reset = 1'b1; tick = 1'b1;
    cyc(1);
    reset = 1'b0; tick = 1'b0;
    cyc(1);

    // Left-turn skip: only through-traffic requests
    veh_req_a = 1'b1; veh_req_b = 1'b1;
    cyc(1);
    veh_req_a = 1'b0; veh_req_b = 1'b0;
    expect_ev(4'd2, 6'd40, 2);
    expect_ev(4'd3, 6'd5,  40);
    expect_ev(4'd4, 6'd2,  5);
    expect_ev(4'd6, 6'd30, 2);
    ticks(59);
    veh_req_a = 1'b1;
    cyc(1);
    veh_req_a = 1'b0;
    expect_ev(4'd7, 6'd5, 30);
    expect_ev(4'd0, 6'd2, 5);
    ticks(25);

    // Rest in A_GREEN for 100 ticks; left_req_a latched during green
    expect_ev(4'd2, 6'd40, 2);
    ticks(2);
    ticks(39);
    left_req_a = 1'b1;
    cyc(1);
    left_req_a = 1'b0;
    ticks(100);
    veh_req_b = 1'b1;
    cyc(1);
    veh_req_b = 1'b0;
    expect_ev(4'd3, 6'd5,  140);
    expect_ev(4'd4, 6'd2,  5);
    expect_ev(4'd6, 6'd30, 2);
    expect_ev(4'd7, 6'd5,  30);
    expect_ev(4'd0, 6'd2,  5);
    expect_ev(4'd1, 6'd15, 2);
    ticks(1 + 5 + 2 + 30 + 5 + 2);

    // left_req_a during A_LEFT is dropped
    ticks(3);
    left_req_a = 1'b1; veh_req_b = 1'b1;
    cyc(1);
    left_req_a = 1'b0; veh_req_b = 1'b0;
    expect_ev(4'd2, 6'd40, 15);
    expect_ev(4'd3, 6'd5,  40);
    expect_ev(4'd4, 6'd2,  5);
    expect_ev(4'd6, 6'd30, 2);
    ticks(12 + 40 + 5 + 2);
    veh_req_a = 1'b1;
    cyc(1);
    veh_req_a = 1'b0;
    expect_ev(4'd7, 6'd5,  30);
    expect_ev(4'd0, 6'd2,  5);
    expect_ev(4'd2, 6'd40, 2);
    ticks(30 + 5 + 2);

    // Flash from mid B_GREEN; a left-turn request latched before flash survives it
    veh_req_b = 1'b1;
    cyc(1);
    veh_req_b = 1'b0;
    expect_ev(4'd3, 6'd5,  40);
    expect_ev(4'd4, 6'd2,  5);
    expect_ev(4'd6, 6'd30, 2);
    ticks(40 + 5 + 2 + 10);
    left_req_a = 1'b1;
    cyc(1);
    left_req_a = 1'b0;
    expect_ev(4'd8, 6'd0, -1, 1'b1);
    enable = 1'b0; tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    expect_ev(4'd8, 6'd0, 1, 1'b0);
    expect_ev(4'd8, 6'd0, 1, 1'b1);
    ticks(2, 2);
    expect_ev(4'd0, 6'd2, -1);
    enable = 1'b1;
    cyc(2);
    expect_ev(4'd1, 6'd15, 2);
    expect_ev(4'd2, 6'd40, 15);
    ticks(17);

    cyc(5);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
